uart_rx_core: RTL and testbench

Parametrised UART receiver. It replaces the fixed 8N1 receive path and generalises data width, parity and stop bits. It adds false-start rejection, parity, framing and break detection. It sits between the board RXD pin and consumers such as the seven-segment display path or a command decoder, and delivers one registered word per frame with a single-cycle valid strobe.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sync.sv | 57 +++++
 rtl/uart_rx_core.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// The receiver's optional majority-vote sampling is controlled by UART_RX_MAJORITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Parity bit a transmitter sends for this data word (unused bits must be zero).
  function automatic logic par_calc(input logic [8:0] data, input int mode);
    logic x;
    x = ^data;
    case (mode)
      PAR_ODD:  par_calc = ~x;
      PAR_EVEN: par_calc = x;
      default:  par_calc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: optional inversion, two-flop
// synchroniser, edge-detect flop and the armed flag that gates start edges.
module uart_rx_sync #(
  parameter int INVERT_RX = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  input  logic disarm,
  output logic rx_s,
  output logic start_edge
);

  logic       rx_in;
  logic       rx_meta;
  logic       rx_d;
  logic       armed;
  logic [1:0] fill;

  assign rx_in = (INVERT_RX != 0) ? ~rxd : rxd;

  // Synchronise the line and keep one extra delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Track when rx_s holds a real line sample rather than its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= 2'b00;
    end else begin
      fill <= {fill[0], 1'b1};
    end
  end

  // Arm only after genuinely seeing the idle-high line; a break disarms until the line recovers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (fill[1] && rx_s) begin
      armed <= 1'b1;
    end else if (disarm) begin
      armed <= 1'b0;
    end
  end

  assign start_edge = armed & rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// with false-start rejection and parity/framing/break reporting.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre
// (needs CLKS_PER_BIT >= 6, adds one cycle of latency).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int INVERT_RX    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_DEC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t               state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_acc;
  logic                 frm_acc;
  logic                 all_low;
  logic                 disarm;
  logic                 rx_s;
  logic                 start_edge;
  logic                 sample;

  uart_rx_sync #(
    .INVERT_RX(INVERT_RX)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .disarm    (disarm),
    .rx_s      (rx_s),
    .start_edge(start_edge)
  );

`ifdef UART_RX_MAJORITY_EN
  // With voting, every decision moves one count later so the third vote is the centre+1 sample.
  localparam logic [CW-1:0] START_DEC = CW'((CLKS_PER_BIT - 1) / 2 + 1);

  logic [1:0] hist;

  // Keep the two previous synchronised samples for the 2-of-3 vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  localparam logic [CW-1:0] START_DEC = CW'((CLKS_PER_BIT - 1) / 2);

  assign sample = rx_s;
`endif

  assign busy = (state != IDLE);

  // Frame FSM: half-bit start qualification, then one decision per bit period; results registered on the last stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_err_acc <= 1'b0;
      frm_acc     <= 1'b0;
      all_low     <= 1'b0;
      disarm      <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      disarm     <= 1'b0;
      clk_cnt    <= clk_cnt + 1'b1;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (start_edge) begin
            state <= START;
          end
        end
        START: begin
          if (clk_cnt == START_DEC) begin
            clk_cnt <= '0;
            if (sample) begin
              state <= IDLE;
            end else begin
              state       <= DATA;
              bit_cnt     <= '0;
              all_low     <= 1'b1;
              frm_acc     <= 1'b0;
              par_err_acc <= 1'b0;
            end
          end
        end
        DATA: begin
          if (clk_cnt == BIT_DEC) begin
            clk_cnt <= '0;
            shreg   <= {sample, shreg[DATA_BITS-1:1]};
            all_low <= all_low & ~sample;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (clk_cnt == BIT_DEC) begin
            clk_cnt     <= '0;
            par_err_acc <= (sample != par_calc(9'(shreg), PARITY_MODE));
            all_low     <= all_low & ~sample;
            state       <= STOP;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_DEC) begin
            clk_cnt <= '0;
            if (STOP_BITS == 2 && bit_cnt == '0) begin
              bit_cnt <= 1'b1;
              frm_acc <= frm_acc | ~sample;
              all_low <= all_low & ~sample;
            end else begin
              bit_cnt    <= '0;
              state      <= IDLE;
              data       <= shreg;
              data_valid <= 1'b1;
              parity_err <= par_err_acc;
              frame_err  <= frm_acc | ~sample;
              break_det  <= all_low & ~sample;
              disarm     <= all_low & ~sample;
            end
          end
        end
        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: an 8N1 instance and an 8E2 instance,
// both at 8 clocks per bit, driven with directed and random serial frames.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int C    = 8;
  localparam int HALF = (C - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_a = 1'b1;
  logic       rxd_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       dv_a, dv_b, pe_a, pe_b, fe_a, fe_b, bd_a, bd_b, busy_a, busy_b;
  logic       prev_dv_a = 1'b0;
  logic       prev_dv_b = 1'b0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  uart_rx_core #(
    .CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .INVERT_RX(0)
  ) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .data(data_a), .data_valid(dv_a),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a), .busy(busy_a)
  );

  uart_rx_core #(
    .CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .INVERT_RX(0)
  ) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .data(data_b), .data_valid(dv_b),
    .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  // Build the line levels of one frame, predict the receiver's report from them, and drive it.
  task automatic applyStimulus(input int sel, input logic [7:0] word, input logic par_flip,
                               input logic [1:0] stop_lv, input int idle_bits);
    logic lv[$];
    int   pmode, nstop, c0;
    logic pbit, all_low, any_stop_low;
    exp_t e;
    pmode = (sel == 0) ? 0 : 2;
    nstop = (sel == 0) ? 1 : 2;
    pbit  = 1'b0;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(word[i]);
    if (pmode != 0) begin
      pbit = (pmode == 1) ? ~(^word) : (^word);
      pbit = pbit ^ par_flip;
      lv.push_back(pbit);
    end
    any_stop_low = 1'b0;
    for (int s = 0; s < nstop; s++) begin
      lv.push_back(stop_lv[s]);
      if (!stop_lv[s]) any_stop_low = 1'b1;
    end
    all_low = 1'b1;
    for (int i = 1; i < lv.size(); i++) if (lv[i]) all_low = 1'b0;
    e.data = word;
    e.pe   = (pmode == 1) ? ~(^{word, pbit}) : (pmode == 2) ? (^{word, pbit}) : 1'b0;
    e.fe   = any_stop_low;
    e.bd   = all_low;
    @(negedge clk);
    c0 = cyc;
    // 2 sync cycles, 1 to enter START, half-bit count, 1 decision edge, then one period per bit after start
    e.at = c0 + 2 + 1 + HALF + 1 + (lv.size() - 1) * C + EXTRA;
    if (sel == 0) q_a.push_back(e);
    else q_b.push_back(e);
    foreach (lv[i]) begin
      set_line(sel, lv[i]);
      repeat (C) @(negedge clk);
    end
    set_line(sel, 1'b1);
    repeat (idle_bits * C) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", q_a.size() + q_b.size(), 0);
  endtask

  // Monitor for the 8N1 instance: pop expected report on each strobe.
  always @(negedge clk) begin
    exp_t e;
    if (dv_a) begin
      checkOutput("a_strobe_width", prev_dv_a, 0);
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL a_unexpected_strobe data=%0h expected no strobe", data_a);
      end else begin
        e = q_a.pop_front();
        checkOutput("a_data", data_a, e.data);
        checkOutput("a_parity_err", pe_a, e.pe);
        checkOutput("a_frame_err", fe_a, e.fe);
        checkOutput("a_break_det", bd_a, e.bd);
        checkOutput("a_latency", cyc, e.at);
      end
    end
    prev_dv_a <= dv_a;
  end

  // Monitor for the 8E2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (dv_b) begin
      checkOutput("b_strobe_width", prev_dv_b, 0);
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL b_unexpected_strobe data=%0h expected no strobe", data_b);
      end else begin
        e = q_b.pop_front();
        checkOutput("b_data", data_b, e.data);
        checkOutput("b_parity_err", pe_b, e.pe);
        checkOutput("b_frame_err", fe_b, e.fe);
        checkOutput("b_break_det", bd_b, e.bd);
        checkOutput("b_latency", cyc, e.at);
      end
    end
    prev_dv_b <= dv_b;
  end

  // Hard stop in case something wedges the stimulus.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_cnt;
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_a_data", data_a, 0);
    checkOutput("rst_a_valid", dv_a, 0);
    checkOutput("rst_a_flags", {pe_a, fe_a, bd_a}, 0);
    checkOutput("rst_a_busy", busy_a, 0);
    checkOutput("rst_b_data", data_b, 0);
    checkOutput("rst_b_valid", dv_b, 0);
    checkOutput("rst_b_flags", {pe_b, fe_b, bd_b}, 0);
    checkOutput("rst_b_busy", busy_b, 0);
    rst = 1'b0;
    repeat (2 * C) @(negedge clk);

    // Clean 8N1 frame
    applyStimulus(0, 8'hA5, 1'b0, 2'b11, 2);
    // Even parity: wrong parity bit, then correct
    applyStimulus(1, 8'h03, 1'b1, 2'b11, 2);
    applyStimulus(1, 8'h03, 1'b0, 2'b11, 2);
    // Second stop bit low
    applyStimulus(1, 8'h81, 1'b0, 2'b01, 2);
    wait_drain();

    // Short low glitch: false start, busy for the half-bit qualification only
    @(negedge clk);
    rxd_a = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 4 * C; i++) begin
      @(negedge clk);
      if (i == 2) rxd_a = 1'b1;
      if (busy_a) busy_cnt++;
    end
    checkOutput("glitch_busy_cycles", busy_cnt, 4 + EXTRA);
    applyStimulus(0, 8'h5A, 1'b0, 2'b11, 2);
    wait_drain();

    // Line held low for 20 bit times: one break report, no retrigger
    begin
      exp_t e;
      @(negedge clk);
      e.data = 8'h00;
      e.pe   = 1'b0;
      e.fe   = 1'b1;
      e.bd   = 1'b1;
      e.at   = cyc + 2 + 1 + HALF + 1 + 9 * C + EXTRA;
      q_a.push_back(e);
      rxd_a = 1'b0;
      repeat (20 * C) @(negedge clk);
      rxd_a = 1'b1;
      repeat (3 * C) @(negedge clk);
    end
    checkOutput("break_reported", q_a.size(), 0);
    applyStimulus(0, 8'hC3, 1'b0, 2'b11, 2);
    wait_drain();

    // Reset during data bit 3 with the line low: the aborted frame must not report
    @(negedge clk);
    rxd_a = 1'b0;
    repeat (C + 3 * C + C / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_busy", busy_a, 0);
    checkOutput("midrst_valid", dv_a, 0);
    rst = 1'b0;
    repeat (C / 2 + 4 * C) @(negedge clk);
    rxd_a = 1'b1;
    repeat (3 * C) @(negedge clk);
    applyStimulus(0, 8'h3C, 1'b0, 2'b11, 2);
    wait_drain();

    // Random frames with occasional parity and stop-bit corruption
    for (int n = 0; n < 40; n++) begin
      logic [7:0] w;
      logic       pf;
      logic [1:0] st;
      w  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) w = 8'h00;
      pf = ($urandom_range(0, 3) == 0);
      st[0] = ($urandom_range(0, 4) != 0);
      st[1] = ($urandom_range(0, 4) != 0);
      applyStimulus(n % 2, w, pf, st, 1 + $urandom_range(0, 1));
    end
    wait_drain();
    repeat (4 * C) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
